// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions for the register-bus bridges (master and slave
// adapters): response codes, the master adapter state encoding and a helper
// that classifies a response as an error.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } mst_state_e;

   // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/axi4_lite_master_adapter.sv
// Register-request to AXI4-Lite master bridge. Local logic (config sequencer,
// test harness) issues single read/write commands; each becomes one AXI4-Lite
// transaction and yields one response word. One transaction outstanding.
//
// Ports:
//   aclk, aresetn        clock, async active-low reset
//   cmd_*                command handshake (valid/ready) + write/addr/wdata/wstrb/prot
//   rsp_*                response handshake (valid/ready) + write/rdata/resp/err
//   busy                 high whenever not IDLE
//   aw*/w*/b*/ar*/r*     AXI4-Lite master channels; every output is a flop
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W valids raised, each dropped after its own handshake
// WR_RESP | bready high, waiting for bvalid
// RD_REQ  | arvalid raised, waiting for arready
// RD_RESP | rready high, waiting for rvalid
// RSP     | rsp_valid high, waiting for rsp_ready
module axi4_lite_master_adapter
   import axi4_lite_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 12,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
   input  logic [AXI_BYTE_COUNT-1:0] cmd_wstrb,
   input  logic [2:0]                cmd_prot,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_err,
   output logic                      busy,
   output logic [AXI_ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]                awprot,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [AXI_DATA_WIDTH-1:0] wdata,
   output logic [AXI_BYTE_COUNT-1:0] wstrb,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic [AXI_ADDR_WIDTH-1:0] araddr,
   output logic [2:0]                arprot,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [AXI_DATA_WIDTH-1:0] rdata,
   input  logic [1:0]                rresp,
   input  logic                      rvalid,
   output logic                      rready
);

   mst_state_e                state_q, state_d;
   logic                      cmd_ready_q, cmd_ready_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]                prot_q, prot_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [AXI_BYTE_COUNT-1:0] wstrb_q, wstrb_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;
   logic                      bready_q, bready_d;
   logic                      arvalid_q, arvalid_d;
   logic                      rready_q, rready_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_write_q, rsp_write_d;
   logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                rsp_resp_q, rsp_resp_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      prot_d      = prot_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_d  = cmd_addr;
               prot_d  = cmd_prot;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            if (awvalid_q && awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            // Uses the _d flags so a same-cycle AW+W handshake moves on at once.
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               rsp_resp_d  = bresp;
               rsp_rdata_d = '0;
               rsp_write_d = 1'b1;
               rsp_valid_d = 1'b1;
               bready_d    = 1'b0;
               state_d     = RSP;
            end
         end
         RD_REQ: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (rvalid) begin
               rsp_rdata_d = rdata;
               rsp_resp_d  = rresp;
               rsp_write_d = 1'b0;
               rsp_valid_d = 1'b1;
               rready_d    = 1'b0;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered so cmd_ready rises one edge after reset release.
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         addr_q      <= '0;
         prot_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         addr_q      <= addr_d;
         prot_q      <= prot_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign rsp_err   = resp_is_err(rsp_resp_q);

   // One latched address/prot serves both AW and AR; only one is ever valid.
   assign awaddr  = addr_q;
   assign awprot  = prot_q;
   assign awvalid = awvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wvalid  = wvalid_q;
   assign bready  = bready_q;
   assign araddr  = addr_q;
   assign arprot  = prot_q;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_adapter.sv
module tb_axi4_lite_master_adapter;
   import axi4_lite_pkg::*;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int BC = DW / 8;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [BC-1:0] cmd_wstrb;
   logic [2:0]    cmd_prot;
   logic          rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [BC-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   axi4_lite_master_adapter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_err(rsp_err), .busy(busy),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic          wr;
      logic [DW-1:0] data;
      logic [1:0]    resp;
   } rsp_t;

   rsp_t                 exp_rsp[$];
   logic [AW+2:0]        aw_q[$];   // {addr, prot}
   logic [DW+BC-1:0]     w_q[$];    // {data, strb}
   logic [AW+2:0]        ar_q[$];   // {addr, prot}
   logic [1:0]           b_q[$];
   logic [DW+1:0]        r_q[$];    // {data, resp}

   int n_vec = 0;
   int n_err = 0;

   // slave / consumer knobs
   int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0, rsp_delay = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // AXI slave model: decides at each falling edge what the next rising edge
   // will see, so a handshake is known exactly when ready is driven.
   initial begin : slave
      int  aw_wait, w_wait, ar_wait, b_wait, r_wait, aw_beats, w_beats;
      bit  aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_done, w_done, b_pend, r_pend;
      logic [DW+1:0] rv;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_beats = 0; w_beats = 0;
      aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
      aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            aw_beats = 0; w_beats = 0;
            aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
            aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
            continue;
         end
         if (aw_fire) begin check("awvalid_drop", awvalid, 0); aw_fire = 0; end
         if (w_fire)  begin check("wvalid_drop", wvalid, 0);   w_fire = 0;  end
         if (ar_fire) begin check("arvalid_drop", arvalid, 0); ar_fire = 0; end
         if (b_fire) begin bvalid = 0; b_fire = 0; end
         if (r_fire) begin rvalid = 0; r_fire = 0; end

         // B: only after both AW and W handshakes have completed
         if (aw_done && w_done) begin b_pend = 1; aw_done = 0; w_done = 0; end
         if (b_pend && !bvalid) begin
            if (b_wait >= b_delay) begin
               check("aw_beats", aw_beats, 1);
               check("w_beats", w_beats, 1);
               aw_beats = 0; w_beats = 0;
               bresp = (b_q.size() != 0) ? b_q.pop_front() : 2'b00;
               bvalid = 1; b_pend = 0; b_wait = 0;
            end else b_wait++;
         end
         if (r_pend && !rvalid) begin
            if (r_wait >= r_delay) begin
               rv = (r_q.size() != 0) ? r_q.pop_front() : '0;
               rdata = rv[DW+1:2]; rresp = rv[1:0];
               rvalid = 1; r_pend = 0; r_wait = 0;
            end else r_wait++;
         end

         awready = 0;
         if (awvalid) begin
            if (aw_q.size() == 0) check("aw_unexpected", awvalid, 0);
            else check("aw_addr_prot", {awaddr, awprot}, aw_q[0]);
            if (aw_wait >= aw_delay) begin
               awready = 1; aw_fire = 1; aw_done = 1; aw_beats++; aw_wait = 0;
               if (aw_q.size() != 0) void'(aw_q.pop_front());
            end else aw_wait++;
         end
         wready = 0;
         if (wvalid) begin
            if (w_q.size() == 0) check("w_unexpected", wvalid, 0);
            else check("w_data_strb", {wdata, wstrb}, w_q[0]);
            if (w_wait >= w_delay) begin
               wready = 1; w_fire = 1; w_done = 1; w_beats++; w_wait = 0;
               if (w_q.size() != 0) void'(w_q.pop_front());
            end else w_wait++;
         end
         arready = 0;
         if (arvalid) begin
            if (ar_q.size() == 0) check("ar_unexpected", arvalid, 0);
            else check("ar_addr_prot", {araddr, arprot}, ar_q[0]);
            if (ar_wait >= ar_delay) begin
               arready = 1; ar_fire = 1; r_pend = 1; ar_wait = 0;
               if (ar_q.size() != 0) void'(ar_q.pop_front());
            end else ar_wait++;
         end
         b_fire = bvalid && bready;
         r_fire = rvalid && rready;
      end
   end

   // Response consumer / scoreboard checker
   initial begin : consumer
      int hold;
      bit fired;
      rsp_t e;
      rsp_ready = 0; hold = 0; fired = 0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin rsp_ready = 0; hold = 0; fired = 0; continue; end
         if (fired) begin
            check("cmd_ready_after_rsp", {cmd_ready, busy}, 2'b10);
            fired = 0;
         end
         rsp_ready = 0;
         if (rsp_valid) begin
            check("quiet_during_rsp", {awvalid, wvalid, arvalid, cmd_ready}, 4'b0000);
            if (exp_rsp.size() == 0) check("rsp_unexpected", rsp_valid, 0);
            else begin
               e = exp_rsp[0];
               check("rsp_fields", {rsp_write, rsp_resp, rsp_err, rsp_rdata},
                     {e.wr, e.resp, e.resp[1], e.data});
            end
            if (hold >= rsp_delay) begin
               rsp_ready = 1; fired = 1; hold = 0;
               if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
            end else hold++;
         end
      end
   end

   // Drives one command and returns at the falling edge after acceptance,
   // leaving cmd_valid high so a following call can issue back-to-back.
   task automatic do_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BC-1:0] s, input logic [2:0] p,
                         input logic [1:0] resp, input logic [DW-1:0] rd);
      int n;
      rsp_t e;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
      cmd_valid = 1;
      e.wr = wr; e.resp = resp;
      if (wr) begin
         aw_q.push_back({a, p}); w_q.push_back({d, s}); b_q.push_back(resp);
         e.data = '0;
      end else begin
         ar_q.push_back({a, p}); r_q.push_back({rd, resp});
         e.data = rd;
      end
      exp_rsp.push_back(e);
      n = 0;
      while (!cmd_ready && n < 200) begin @(negedge aclk); n++; end
      check("cmd_accept", cmd_ready, 1);
      @(negedge aclk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_rsp.size() != 0 || busy) && n < 300) begin @(negedge aclk); n++; end
      check("drain_rsp_q", exp_rsp.size(), 0);
      check("drain_idle", busy, 0);
   endtask

   initial begin : main
      int n;
      bit wr;
      logic [DW-1:0] rnd_d;
      aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
      cmd_wdata = 0; cmd_wstrb = 0; cmd_prot = 0;

      // reset state
      #12;
      check("rst_ctrl", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready, busy}, 8'h00);
      check("rst_aw_w", {awaddr, awprot, wdata, wstrb}, '0);
      check("rst_ar", {araddr, arprot}, '0);
      check("rst_rsp", {rsp_write, rsp_resp, rsp_err, rsp_rdata}, '0);
      @(negedge aclk); #2 aresetn = 1;
      #1 check("cmd_ready_pre_edge", cmd_ready, 0);
      @(posedge aclk); #1 check("cmd_ready_post_edge", cmd_ready, 1);
      @(negedge aclk);

      // zero-wait write; accept cycle is cycle 0, rsp_valid high in cycle 3
      do_cmd(1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b010, OKAY, '0);
      cmd_valid = 0;
      n = 1;
      while (!rsp_valid && n < 20) begin @(negedge aclk); n++; end
      check("wr_latency", n, 3);
      drain();

      // W accepted 4 cycles after AW
      w_delay = 4;
      do_cmd(1, 12'h014, 32'hCAFEF00D, 4'h5, 3'b001, OKAY, '0);
      cmd_valid = 0;
      drain();
      w_delay = 0;

      // read with SLVERR after 2 cycles of arready low
      ar_delay = 2;
      do_cmd(0, 12'h020, '0, '0, 3'b000, SLVERR, 32'h12345678);
      cmd_valid = 0;
      drain();
      ar_delay = 0;

      // rsp_ready held off 5 cycles
      rsp_delay = 5;
      do_cmd(0, 12'h030, '0, '0, 3'b100, OKAY, 32'hA5A50F0F);
      cmd_valid = 0;
      drain();
      rsp_delay = 0;

      // back-to-back write then read, cmd_valid held high throughout
      do_cmd(1, 12'h040, 32'h11223344, 4'hC, 3'b011, DECERR, '0);
      do_cmd(0, 12'h044, '0, '0, 3'b101, EXOKAY, 32'h55AA55AA);
      cmd_valid = 0;
      drain();

      // mixed commands with random slave stalls
      for (int i = 0; i < 8; i++) begin
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 2);
         r_delay = $urandom_range(0, 2);  rsp_delay = $urandom_range(0, 2);
         wr = 1'($urandom_range(0, 1));
         rnd_d = $urandom;
         do_cmd(wr, 12'($urandom_range(0, 4095)), rnd_d, 4'($urandom_range(0, 15)),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), ~rnd_d);
         cmd_valid = 0;
         drain();
      end
      aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0; rsp_delay = 0;

      // reset with AW and W both pending
      aw_delay = 50; w_delay = 50;
      do_cmd(1, 12'h080, 32'h0BADF00D, 4'hF, 3'b000, OKAY, '0);
      cmd_valid = 0;
      check("pending_valids", {awvalid, wvalid}, 2'b11);
      #2 aresetn = 0;
      #1 check("midrst_ctrl", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready, busy}, 8'h00);
      check("midrst_aw_w", {awaddr, awprot, wdata, wstrb}, '0);
      exp_rsp.delete(); aw_q.delete(); w_q.delete(); ar_q.delete(); b_q.delete(); r_q.delete();
      aw_delay = 0; w_delay = 0;
      @(negedge aclk); @(negedge aclk); #2 aresetn = 1;
      #1 check("rel_cmd_ready_pre", cmd_ready, 0);
      @(posedge aclk); #1 check("rel_cmd_ready_post", cmd_ready, 1);
      @(negedge aclk);

      // recovery read
      do_cmd(0, 12'h0FC, '0, '0, 3'b010, OKAY, 32'hFEEDFACE);
      cmd_valid = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
